// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared grid constants, fill state and rectangle command types
package vga_pkg;
    localparam int GRID_W = 64;
    localparam int GRID_H = 64;
    localparam int ADDR_W = 12;
    localparam int PIX_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

    typedef struct packed {
        logic [5:0]       x;
        logic [5:0]       y;
        logic [6:0]       w;
        logic [6:0]       h;
        logic [PIX_W-1:0] color;
    } rect_cmd_t;
endpackage

// File: rtl/rect_clip.sv
// rtl/rect_clip.sv - clips a rectangle against the grid; combinational
module rect_clip #(
    parameter int GRID_W = 64,
    parameter int GRID_H = 64
) (
    input  logic [5:0] x,
    input  logic [5:0] y,
    input  logic [6:0] w,
    input  logic [6:0] h,
    output logic [6:0] cw,
    output logic [6:0] ch,
    output logic       empty
);
    logic [6:0] room_x;
    logic [6:0] room_y;

    always_comb begin
        room_x = 7'(GRID_W) - {1'b0, x};
        room_y = 7'(GRID_H) - {1'b0, y};
        cw     = (w < room_x) ? w : room_x;
        ch     = (h < room_y) ? h : room_y;
        empty  = (cw == 7'd0) || (ch == 7'd0);
    end
endmodule

// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - rectangle fill into the tile memory, one pixel per cycle
module rect_fill_engine #(
    parameter int GRID_W     = vga_pkg::GRID_W,
    parameter int GRID_H     = vga_pkg::GRID_H,
    parameter int GATE_BLANK = 1
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic                       blank,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [5:0]                 cmd_x,
    input  logic [5:0]                 cmd_y,
    input  logic [6:0]                 cmd_w,
    input  logic [6:0]                 cmd_h,
    input  logic [vga_pkg::PIX_W-1:0]  cmd_color,
    output logic                       mem_we,
    output logic [vga_pkg::ADDR_W-1:0] mem_addr,
    output logic [vga_pkg::PIX_W-1:0]  mem_din,
    output logic                       busy,
    output logic                       done
);
    import vga_pkg::*;

    fill_state_e      state_q, state_d;
    logic [5:0]       cx_q, cx_d, cy_q, cy_d;
    logic [5:0]       x0_q, x0_d, ex_q, ex_d, ey_q, ey_d;
    logic [PIX_W-1:0] color_q, color_d;
    logic             cmd_ready_q, cmd_ready_d;
    rect_cmd_t        cmd_in;
    logic [6:0]       cw, ch;
    logic             empty;
    logic             pix_en;

    assign cmd_in = '{cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};

    rect_clip #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_clip (
        .x     (cmd_in.x),
        .y     (cmd_in.y),
        .w     (cmd_in.w),
        .h     (cmd_in.h),
        .cw    (cw),
        .ch    (ch),
        .empty (empty)
    );

    assign pix_en = (GATE_BLANK == 0) || blank;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x0_d    = x0_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        color_d = color_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    // Store the inclusive end corner so the scan only needs equality compares
                    cx_d    = cmd_in.x;
                    cy_d    = cmd_in.y;
                    x0_d    = cmd_in.x;
                    ex_d    = 6'({1'b0, cmd_in.x} + cw - 7'd1);
                    ey_d    = 6'({1'b0, cmd_in.y} + ch - 7'd1);
                    color_d = cmd_in.color;
                    state_d = empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (pix_en) begin
                    mem_we = 1'b1;
                    if (cx_q == ex_q) begin
                        cx_d = x0_q;
                        if (cy_q == ey_q) begin
                            state_d = DONE;
                        end else begin
                            cy_d = cy_q + 6'd1;
                        end
                    end else begin
                        cx_d = cx_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            x0_q        <= '0;
            ex_q        <= '0;
            ey_q        <= '0;
            color_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            x0_q        <= x0_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            color_q     <= color_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mem_addr  = {cy_q, cx_q};
    assign mem_din   = color_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb/tb_rect_fill_engine.sv - directed bench for rect_fill_engine, ungated and gated instances
module tb_rect_fill_engine;
    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blank = 1'b1;
    logic        cmd_valid_u = 1'b0;
    logic        cmd_valid_g = 1'b0;
    logic [5:0]  cmd_x = '0;
    logic [5:0]  cmd_y = '0;
    logic [6:0]  cmd_w = '0;
    logic [6:0]  cmd_h = '0;
    logic [11:0] cmd_color = '0;

    logic        cmd_ready_u, mem_we_u, busy_u, done_u;
    logic [11:0] mem_addr_u, mem_din_u;
    logic        cmd_ready_g, mem_we_g, busy_g, done_g;
    logic [11:0] mem_addr_g, mem_din_g;

    always #5 pclk = ~pclk;

    rect_fill_engine #(.GRID_W(64), .GRID_H(64), .GATE_BLANK(0)) u_ung (
        .pclk(pclk), .rst_n(rst_n), .blank(blank),
        .cmd_valid(cmd_valid_u), .cmd_ready(cmd_ready_u),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .mem_we(mem_we_u), .mem_addr(mem_addr_u), .mem_din(mem_din_u),
        .busy(busy_u), .done(done_u)
    );

    rect_fill_engine #(.GRID_W(64), .GRID_H(64), .GATE_BLANK(1)) u_gat (
        .pclk(pclk), .rst_n(rst_n), .blank(blank),
        .cmd_valid(cmd_valid_g), .cmd_ready(cmd_ready_g),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .mem_we(mem_we_g), .mem_addr(mem_addr_g), .mem_din(mem_din_g),
        .busy(busy_g), .done(done_g)
    );

    typedef struct {
        logic [5:0]  x;
        logic [5:0]  y;
        logic [6:0]  w;
        logic [6:0]  h;
        logic [11:0] color;
        int          n;
        int          first;
        int          last;
    } vec_t;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int wa_u[$], wd_u[$], wc_u[$], dn_u[$];
    int wa_g[$], wc_g[$], dn_g[$];
    int busy_u_cnt = 0;
    int viol_g = 0;

    // Write/done log, sampled on the falling edge
    initial forever begin
        @(negedge pclk);
        cyc++;
        if (mem_we_u) begin
            wa_u.push_back(int'(mem_addr_u));
            wd_u.push_back(int'(mem_din_u));
            wc_u.push_back(cyc);
        end
        if (done_u) dn_u.push_back(cyc);
        if (busy_u) busy_u_cnt++;
        if (mem_we_g) begin
            wa_g.push_back(int'(mem_addr_g));
            wc_g.push_back(cyc);
            if (!blank) viol_g++;
        end
        if (done_g) dn_g.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cmd(input logic [5:0] x, input logic [5:0] y, input logic [6:0] w,
                           input logic [6:0] h, input logic [11:0] c);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    endtask

    task automatic run_u(input vec_t v, output int acc, output int wb, output int db, output int bb);
        wb = wa_u.size(); db = dn_u.size(); bb = busy_u_cnt;
        set_cmd(v.x, v.y, v.w, v.h, v.color);
        cmd_valid_u = 1'b1;
        step();
        cmd_valid_u = 1'b0;
        acc = cyc;
        for (int k = 0; k < 400 && dn_u.size() == db; k++) step();
        if (dn_u.size() == db) chk("timeout_u", 0, 1);
    endtask

    task automatic run_g(input logic [5:0] x, input logic [5:0] y, input logic [6:0] w,
                         input logic [31:0] pat, output int acc, output int wb, output int db);
        int k;
        wb = wa_g.size(); db = dn_g.size();
        set_cmd(x, y, w, 7'd1, 12'h00F);
        cmd_valid_g = 1'b1;
        step();
        cmd_valid_g = 1'b0;
        acc = cyc;
        k = 0;
        blank = pat[0];
        while (dn_g.size() == db && k < 200) begin
            step();
            k++;
            blank = (k < 32) ? pat[k] : 1'b1;
        end
        blank = 1'b1;
        if (dn_g.size() == db) chk("timeout_g", 0, 1);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int acc, wb, db, bb, n, bad, ord, gap;
        int exp_a[$];
        int exp_k[$];

        vecs[0] = '{6'd2,  6'd3,  7'd3,   7'd2,   12'hF00, 6,   194,  260};
        vecs[1] = '{6'd62, 6'd63, 7'd10,  7'd5,   12'h0F0, 2,   4094, 4095};
        vecs[2] = '{6'd0,  6'd0,  7'd0,   7'd9,   12'h00F, 0,   -1,   -1};
        vecs[3] = '{6'd10, 6'd20, 7'd1,   7'd1,   12'hABC, 1,   1290, 1290};
        vecs[4] = '{6'd60, 6'd0,  7'd127, 7'd2,   12'h123, 8,   60,   127};
        vecs[5] = '{6'd0,  6'd62, 7'd64,  7'd127, 12'h456, 128, 3968, 4095};
        vecs[6] = '{6'd5,  6'd5,  7'd3,   7'd0,   12'h789, 0,   -1,   -1};

        #2;
        chk("rst_ready", int'(cmd_ready_u), 0);
        chk("rst_we", int'(mem_we_u), 0);
        chk("rst_addr", int'(mem_addr_u), 0);
        chk("rst_din", int'(mem_din_u), 0);
        chk("rst_busy", int'(busy_u), 0);
        chk("rst_done", int'(done_u), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", int'(cmd_ready_u), 0);
        step();
        chk("ready_after_edge", int'(cmd_ready_u), 1);
        chk("ready_after_edge_g", int'(cmd_ready_g), 1);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            run_u(v, acc, wb, db, bb);
            n = wa_u.size() - wb;
            chk($sformatf("v%0d_nwrites", i), n, v.n);
            if (n > 0 && v.n > 0) begin
                chk($sformatf("v%0d_first", i), wa_u[wb], v.first);
                chk($sformatf("v%0d_last", i), wa_u[wa_u.size()-1], v.last);
            end
            bad = 0; ord = 0; gap = 0;
            for (int j = wb; j < wa_u.size(); j++) begin
                if (wd_u[j] != int'(v.color)) bad++;
                if (j > wb && wa_u[j] <= wa_u[j-1]) ord++;
                if (j > wb && wc_u[j] != wc_u[j-1] + 1) gap++;
            end
            chk($sformatf("v%0d_data", i), bad, 0);
            chk($sformatf("v%0d_order", i), ord, 0);
            chk($sformatf("v%0d_gaps", i), gap, 0);
            if (dn_u.size() > db) chk($sformatf("v%0d_done_lat", i), dn_u[db] - acc, v.n + 1);
            chk($sformatf("v%0d_busy_cycles", i), busy_u_cnt - bb, v.n + 1);
            chk($sformatf("v%0d_ready_back", i), int'(cmd_ready_u), 1);
        end

        // Exact address list of the first fill and done right after the last write
        run_u(vecs[0], acc, wb, db, bb);
        exp_a = '{194, 195, 196, 258, 259, 260};
        chk("seq_nwrites", wa_u.size() - wb, 6);
        if (wa_u.size() - wb == 6) begin
            for (int j = 0; j < 6; j++) chk($sformatf("seq_addr%0d", j), wa_u[wb+j], exp_a[j]);
            if (dn_u.size() > db) chk("seq_done_after_last", dn_u[db], wc_u[wb+5] + 1);
        end

        // Gated: blank 4 on / 4 off
        run_g(6'd0, 6'd0, 7'd10, 32'h0F0F_0F0F, acc, wb, db);
        exp_k = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17};
        chk("gate_nwrites", wa_g.size() - wb, 10);
        if (wa_g.size() - wb == 10) begin
            for (int j = 0; j < 10; j++) begin
                chk($sformatf("gate_addr%0d", j), wa_g[wb+j], j);
                chk($sformatf("gate_cyc%0d", j), wc_g[wb+j] - acc - 1, exp_k[j]);
            end
        end
        if (dn_g.size() > db) chk("gate_done_lat", dn_g[db] - acc, 19);
        chk("gate_violations", viol_g, 0);

        // Gated: blank drops exactly on the last-pixel cycle
        run_g(6'd7, 6'd1, 7'd3, 32'hFFFF_FFFB, acc, wb, db);
        exp_a = '{71, 72, 73};
        exp_k = '{0, 1, 3};
        chk("lastdrop_nwrites", wa_g.size() - wb, 3);
        if (wa_g.size() - wb == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("lastdrop_addr%0d", j), wa_g[wb+j], exp_a[j]);
                chk($sformatf("lastdrop_cyc%0d", j), wc_g[wb+j] - acc - 1, exp_k[j]);
            end
        end
        if (dn_g.size() > db) chk("lastdrop_done_lat", dn_g[db] - acc, 5);
        chk("lastdrop_violations", viol_g, 0);

        // Asynchronous reset in the middle of a full-grid fill
        wb = wa_u.size();
        set_cmd(6'd0, 6'd0, 7'd64, 7'd64, 12'h555);
        cmd_valid_u = 1'b1;
        step();
        cmd_valid_u = 1'b0;
        for (int k = 0; k < 50 && wa_u.size() - wb < 5; k++) step();
        chk("midfill_5_writes", wa_u.size() - wb, 5);
        rst_n = 1'b0;
        #1;
        chk("midfill_rst_we", int'(mem_we_u), 0);
        chk("midfill_rst_busy", int'(busy_u), 0);
        chk("midfill_rst_ready", int'(cmd_ready_u), 0);
        wb = wa_u.size();
        step();
        step();
        chk("midfill_no_writes_in_rst", wa_u.size() - wb, 0);
        rst_n = 1'b1;
        #2;
        chk("midfill_ready_before_edge", int'(cmd_ready_u), 0);
        step();
        chk("midfill_ready_after_edge", int'(cmd_ready_u), 1);
        v = '{6'd0, 6'd0, 7'd1, 7'd1, 12'h321, 1, 0, 0};
        run_u(v, acc, wb, db, bb);
        chk("post_rst_nwrites", wa_u.size() - wb, 1);
        if (wa_u.size() - wb == 1) chk("post_rst_addr", wa_u[wb], 0);

        // Back-to-back with cmd_valid held and fields changed right after accept
        wb = wa_u.size(); db = dn_u.size();
        set_cmd(6'd1, 6'd1, 7'd2, 7'd1, 12'h111);
        cmd_valid_u = 1'b1;
        step();
        acc = cyc;
        set_cmd(6'd4, 6'd2, 7'd1, 7'd2, 12'h222);
        for (int k = 0; k < 4; k++) step();
        cmd_valid_u = 1'b0;
        for (int k = 0; k < 50 && dn_u.size() - db < 2; k++) step();
        exp_a = '{65, 66, 132, 196};
        exp_k = '{1, 2, 5, 6};
        chk("b2b_nwrites", wa_u.size() - wb, 4);
        if (wa_u.size() - wb == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("b2b_addr%0d", j), wa_u[wb+j], exp_a[j]);
                chk($sformatf("b2b_data%0d", j), wd_u[wb+j], (j < 2) ? 12'h111 : 12'h222);
                chk($sformatf("b2b_cyc%0d", j), wc_u[wb+j] - acc, exp_k[j]);
            end
        end
        chk("b2b_ndone", dn_u.size() - db, 2);
        if (dn_u.size() - db == 2) begin
            chk("b2b_done0", dn_u[db] - acc, 3);
            chk("b2b_done1", dn_u[db+1] - acc, 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Upstream producer for the display tile memory: 4096 x 12-bit RGB444 store, 64x64 pixel grid, write port B.
- Accepts rectangle-fill commands over a valid/ready handshake.
- Writes the clipped rectangle into memory at one pixel per cycle.
- Optionally confines writes to blanking time, so the scan-out side never reads a half-drawn frame.

Parameters:
- GRID_W, 64, pixels per memory row (power of two); address = y*GRID_W + x.
- GRID_H, 64, rows in memory.
- GATE_BLANK, 1, when 1 memory writes occur only while blank=1; when 0 writes are ungated.

Ports:
- pclk  in  1  pixel clock (25 MHz), all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- blank  in  1  high when the display controller is outside the visible area; level signal in the pclk domain.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  6  left column of the rectangle.
- cmd_y  in  6  top row of the rectangle.
- cmd_w  in  7  width, 0..127.
- cmd_h  in  7  height, 0..127.
- cmd_color  in  12  RGB444 fill value.
- mem_we  out  1  memory write enable.
- mem_addr  out  12  memory write address.
- mem_din  out  12  memory write data.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cmd_ready=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0.
  - An in-flight fill is abandoned; no further writes occur.
  - cmd_ready rises on the first pclk edge after rst_n deasserts.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE.
  - All cmd_* fields are registered at acceptance; later changes on cmd_* have no effect.
- Clipping (computed at acceptance, 7-bit arithmetic):
  - cw = min(cmd_w, GRID_W - cmd_x); ch = min(cmd_h, GRID_H - cmd_y).
  - cw=0 or ch=0 gives an empty command.
- State machine:
  - IDLE -> FILL on accept of a non-empty command.
  - IDLE -> DONE on accept of an empty command (no writes).
  - FILL: a pixel is written on a cycle when (GATE_BLANK==0 || blank==1); mem_we=1 with mem_addr = {cy, cx} (cy*64 + cx) and mem_din = color.
  - FILL scan order: raster, cx from cmd_x to cmd_x+cw-1, then cy+1; each row restarts at cmd_x.
  - FILL stall: if gated off (blank=0), mem_we=0 and the cx/cy position holds; writing resumes at the same pixel.
  - FILL -> DONE on the cycle the last pixel (cmd_x+cw-1, cmd_y+ch-1) is written.
  - DONE: done=1 for exactly one cycle, mem_we=0; then -> IDLE with cmd_ready=1.
- Latency:
  - First write is at the earliest on the cycle after acceptance.
  - An ungated fill takes cw*ch write cycles, plus 1 DONE cycle, before cmd_ready returns.
- busy: 1 in FILL and DONE, 0 in IDLE.
- mem_addr and mem_din may hold stale values while mem_we=0; a checker samples them only when mem_we=1.
- Address width: cx and cy are 6-bit; no wrap-around occurs because clipping bounds both.
- Simultaneous events:
  - blank falling on the last-pixel cycle: that write is suppressed and the pixel is written at the next blank=1 cycle.
  - cmd_valid held high through DONE: the next command is accepted on the first IDLE cycle (minimum 1-cycle gap).

Decomposition:
- Shared package vga_pkg:
  - constants GRID_W, GRID_H, ADDR_W=12, PIX_W=12;
  - the fill state enum (IDLE, FILL, DONE);
  - the rectangle command struct (x, y, w, h, color).
- One natural sub-module: rect_clip, purely combinational. It computes cw, ch and the empty flag from x, y, w, h and is reused by future sprite/blit engines.
- The FSM and counters stay in rect_fill_engine.

Test Plan:
- GATE_BLANK=0, cmd (x=2, y=3, w=3, h=2, color=12'hF00):
  - writes 6 consecutive cycles to addrs 194, 195, 196, 258, 259, 260, all with data F00;
  - done pulses 1 cycle after addr 260; cmd_ready=1 the next cycle.
- Clipping, cmd (x=62, y=63, w=10, h=5, color=12'h0F0):
  - exactly 2 writes, to 4094 and 4095;
  - no write to any address below 4032 other than these.
- Empty cmd (w=0, h=9):
  - zero mem_we cycles; done pulses on the cycle after accept; busy high for exactly 1 cycle.
- GATE_BLANK=1, blank toggling 4 cycles on / 4 off, cmd (x=0, y=0, w=10, h=1):
  - mem_we only when blank=1;
  - addrs 0..9 written in order, none skipped or repeated;
  - done follows the 10th write.
- Reset mid-fill: assert rst_n=0 after the 5th write of a 64x64 fill:
  - mem_we=0, busy=0 and cmd_ready=0 immediately (async);
  - cmd_ready=1 one edge after release;
  - a new 1x1 cmd at (0,0) writes only addr 0.
- Back-to-back commands with cmd_valid held high and fields changed right after accept:
  - first command's writes use the latched fields;
  - second command accepted exactly 1 cycle after done.
